acc_segment_sequencer: RTL and testbench
========================================

# acc_segment_sequencer

Feeds motion segments into one `acc_profile_gen` instance and paces it. It accepts segment descriptors over a valid/ready stream and issues each one as a single `load` pulse. It then generates `acc_step` ticks at a fixed clock divide for the segment's duration, and handles the stop and abort sequences. It sits between the host command FIFO and the per-axis profile generator.

## Interface
Parameters:
- `STEP_DIV`, default 50: clocks per `acc_step` tick; must be ≥ 4.
- `DUR_W`, default 32: width of the segment duration counter.

Ports:
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; leaves IDLE and clears the sticky flags. Ignored outside IDLE.
- `abort_req` in 1: level, sampled every cycle. Ignored in IDLE.
- `seg_valid` in 1, `seg_ready` out 1: descriptor handshake. A transfer occurs when both are 1 on a rising `clk` edge.
- `seg_flags` in 7, bits [6:0] = {last, set_target_v, set_jj, set_j, set_a, set_v, set_x}.
- `seg_x` in 64: signed position value.
- `seg_v`, `seg_a`, `seg_j`, `seg_jj`, `seg_target_v` in 32 each: signed values.
- `seg_dur` in `DUR_W`: number of ticks for the segment; 0 means load-only.
- `pg_load` out 1, `pg_acc_step` out 1: profile generator strobes.
- `pg_set_x`, `pg_set_v`, `pg_set_a`, `pg_set_j`, `pg_set_jj`, `pg_set_target_v` out 1 each: valid only with `pg_load`.
- `pg_x_val` out 64; `pg_v_val`, `pg_a_val`, `pg_j_val`, `pg_jj_val`, `pg_target_v_val` out 32 each: held from the last accepted descriptor.
- `pg_abort` out 1: level to the profile generator.
- `pg_stopped` in 1: from the profile generator.
- `busy` out 1: 1 in every state except IDLE.
- `underrun` out 1: sticky flag.
- `aborted` out 1: sticky flag.
- `seg_count` out 16: completed segments, wraps modulo 2^16.

## Operation
States: IDLE, FETCH, LOAD, RUN, STOPPING, ABORT.

State transitions:
- **IDLE**
  - `seg_ready`=0; no ticks are issued.
  - `start` → FETCH. Also clears `underrun`, `aborted`, `seg_count` and the divider.
- **FETCH**
  - `seg_ready`=1.
  - On a handshake: register the descriptor → LOAD.
  - Ticks continue with the current profile ("coast").
  - A tick issued in FETCH after the first segment of a run sets `underrun`.
- **LOAD**
  - Registered `pg_load`=1 for exactly one cycle, with `pg_set_*` equal to the flags.
  - Then: if `seg_dur`=0 → count the segment, go to STOPPING if last is set, else FETCH.
  - Otherwise load `remaining`=`seg_dur` → RUN.
- **RUN**
  - Each issued tick decrements `remaining`.
  - The tick that brings `remaining` to 0 completes the segment: `seg_count`+1.
  - After completion: → STOPPING if last is set, else FETCH.
- **STOPPING**
  - `seg_ready`=0; ticks continue.
  - When `pg_stopped`=1 on the cycle after a tick → IDLE.
- **ABORT**
  - `pg_abort`=1, `seg_ready`=0, ticks continue.
  - When `pg_stopped`=1 on the cycle after a tick → IDLE with `aborted`=1.
  - Any registered descriptor not yet loaded is discarded.

Abort priority:
- `abort_req`=1 in FETCH, LOAD, RUN or STOPPING → ABORT on the next cycle.
- This takes priority over every other transition.
- An abort arriving in the LOAD cycle suppresses that cycle's `pg_load`.

Arithmetic:
- `remaining` is unsigned `DUR_W` bits and never goes below 0.
- The value registers pass through unmodified; no sign handling is done in this block.

## Timing
Reset:
- State → IDLE; divider → 0.
- All outputs → 0, including the `pg_*` value registers.
- Reset asserted mid-run drops the run immediately; no abort sequence is performed.

Tick generation:
- The divider runs in every state except IDLE.
- A tick is due when the divider equals `STEP_DIV`-1; the divider then wraps to 0.
- `pg_acc_step` is registered and lasts one cycle.
- A tick due on a `pg_load` cycle is deferred by exactly one cycle, because the profile generator gives `load` priority. Subsequent ticks keep the original phase.

Latencies:
- `start` at cycle 0 → FETCH at cycle 1, with `seg_ready`=1 at cycle 1.
- Handshake at cycle n → `pg_load`=1 at cycle n+1 → RUN at n+2.
- After the completing tick, FETCH is entered the next cycle. A descriptor presented then arrives well inside one tick interval, so there is no underrun.
- `pg_abort` is asserted the cycle after `abort_req` is first sampled high.

## Structure
- Shared package `acc_seq_pkg` holds:
  - the state enum;
  - `seg_flags` bit index constants (`SF_X`=0 … `SF_LAST`=6);
  - the descriptor record type.
- Sub-module `acc_tick_gen` contains the divider, the tick-due flag and the one-cycle defer logic. Its inputs are `run_en` and `defer`; its output is `tick`.
- The FSM, descriptor register, `remaining` counter and flags live in the top module.

## Test plan
- **Single segment:** `STEP_DIV`=4; start; one descriptor with `set_v`, v=1000, `seg_dur`=5, last=1.
  - Exactly one `pg_load`, then 5 ticks 4 clocks apart, then STOPPING.
  - `seg_count`=1; IDLE once the stub asserts `pg_stopped`.
- **Back-to-back segments:** three segments of `seg_dur`=3 each, with descriptors always valid.
  - Tick spacing stays 4 clocks (a deferred tick gives 5 then 3).
  - `underrun`=0; `seg_count`=3.
- **Underrun:** withhold the second descriptor for 10 clocks.
  - Ticks keep coming; `underrun`=1; the later descriptor still loads.
- **Abort in RUN:** raise `abort_req` with `remaining`=7.
  - `pg_abort`=1 the next cycle and `seg_ready`=0.
  - The stub asserts `pg_stopped` after 2 ticks → IDLE, `aborted`=1, `seg_count` unchanged.
- **Load-only and abort in LOAD:**
  - `seg_dur`=0 descriptor → `pg_load` with no RUN; `seg_count` increments.
  - `abort_req` coincident with LOAD → no `pg_load`.
- **Reset mid-RUN:** assert `reset` during RUN.
  - All outputs 0 the next cycle; IDLE; `start` is required to resume.

Source files
------------

// File: rtl/acc_seq_pkg.sv
// rtl/acc_seq_pkg.sv - shared types and constants for the segment sequencer
package acc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_RUN,
      ST_STOPPING,
      ST_ABORT
   } seq_state_t;

   localparam int SF_X        = 0;
   localparam int SF_V        = 1;
   localparam int SF_A        = 2;
   localparam int SF_J        = 3;
   localparam int SF_JJ       = 4;
   localparam int SF_TARGET_V = 5;
   localparam int SF_LAST     = 6;

   typedef struct packed {
      logic [6:0]  flags;
      logic [63:0] x;
      logic [31:0] v;
      logic [31:0] a;
      logic [31:0] j;
      logic [31:0] jj;
      logic [31:0] target_v;
   } seg_desc_t;

endpackage

// File: rtl/acc_tick_gen.sv
// rtl/acc_tick_gen.sv - fixed-divide step tick generator with one-cycle defer
module acc_tick_gen #(
   parameter int STEP_DIV = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic run_en,
   input  logic defer,
   output logic tick
);

   localparam int DIV_W = $clog2(STEP_DIV);

   logic [DIV_W-1:0] div;
   logic             pend;
   logic             due;

   assign due = (div == DIV_W'(STEP_DIV - 1));

   // A deferred tick is replayed one cycle later; the divider keeps its phase.
   always_ff @(posedge clk) begin
      if (reset || !run_en) begin
         div  <= '0;
         pend <= 1'b0;
         tick <= 1'b0;
      end else begin
         div  <= due ? '0 : div + 1'b1;
         tick <= (due && !defer) || pend;
         pend <= due && defer;
      end
   end

endmodule

// File: rtl/acc_segment_sequencer.sv
// rtl/acc_segment_sequencer.sv - feeds and paces segments into one profile generator
module acc_segment_sequencer
   import acc_seq_pkg::*;
#(
   parameter int STEP_DIV = 50,
   parameter int DUR_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort_req,
   input  logic             seg_valid,
   output logic             seg_ready,
   input  logic [6:0]       seg_flags,
   input  logic [63:0]      seg_x,
   input  logic [31:0]      seg_v,
   input  logic [31:0]      seg_a,
   input  logic [31:0]      seg_j,
   input  logic [31:0]      seg_jj,
   input  logic [31:0]      seg_target_v,
   input  logic [DUR_W-1:0] seg_dur,
   output logic             pg_load,
   output logic             pg_acc_step,
   output logic             pg_set_x,
   output logic             pg_set_v,
   output logic             pg_set_a,
   output logic             pg_set_j,
   output logic             pg_set_jj,
   output logic             pg_set_target_v,
   output logic [63:0]      pg_x_val,
   output logic [31:0]      pg_v_val,
   output logic [31:0]      pg_a_val,
   output logic [31:0]      pg_j_val,
   output logic [31:0]      pg_jj_val,
   output logic [31:0]      pg_target_v_val,
   output logic             pg_abort,
   input  logic             pg_stopped,
   output logic             busy,
   output logic             underrun,
   output logic             aborted,
   output logic [15:0]      seg_count
);

   seq_state_t       state;
   seq_state_t       next_state;
   seg_desc_t        desc;
   logic [DUR_W-1:0] dur_q;
   logic [DUR_W-1:0] remaining;
   logic             load_q;
   logic             tick;
   logic             tick_d;
   logic             seen_seg;
   logic             load_go;
   logic             done_tick;
   logic             last;

   acc_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .run_en (state != ST_IDLE),
      .defer  (next_state == ST_LOAD),
      .tick   (tick)
   );

   assign last      = desc.flags[SF_LAST];
   assign load_go   = (state == ST_LOAD) && !abort_req;
   assign done_tick = (state == ST_RUN) && tick && (remaining == DUR_W'(1));

   always_comb begin
      next_state = state;
      seg_ready  = 1'b0;
      busy       = 1'b1;
      pg_abort   = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) next_state = ST_FETCH;
         end
         ST_FETCH: begin
            seg_ready = 1'b1;
            if (abort_req)      next_state = ST_ABORT;
            else if (seg_valid) next_state = ST_LOAD;
         end
         ST_LOAD: begin
            if (abort_req)         next_state = ST_ABORT;
            else if (dur_q == '0)  next_state = last ? ST_STOPPING : ST_FETCH;
            else                   next_state = ST_RUN;
         end
         ST_RUN: begin
            if (abort_req)      next_state = ST_ABORT;
            else if (done_tick) next_state = last ? ST_STOPPING : ST_FETCH;
         end
         ST_STOPPING: begin
            if (abort_req)                 next_state = ST_ABORT;
            else if (tick_d && pg_stopped) next_state = ST_IDLE;
         end
         ST_ABORT: begin
            pg_abort = 1'b1;
            if (tick_d && pg_stopped) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         desc      <= '0;
         dur_q     <= '0;
         remaining <= '0;
         load_q    <= 1'b0;
         tick_d    <= 1'b0;
         seen_seg  <= 1'b0;
         underrun  <= 1'b0;
         aborted   <= 1'b0;
         seg_count <= '0;
      end else begin
         state  <= next_state;
         tick_d <= tick;
         load_q <= (next_state == ST_LOAD);
         if (state == ST_IDLE && start) begin
            underrun  <= 1'b0;
            aborted   <= 1'b0;
            seg_count <= '0;
            seen_seg  <= 1'b0;
         end
         if (state == ST_FETCH && seg_valid) begin
            desc.flags    <= seg_flags;
            desc.x        <= seg_x;
            desc.v        <= seg_v;
            desc.a        <= seg_a;
            desc.j        <= seg_j;
            desc.jj       <= seg_jj;
            desc.target_v <= seg_target_v;
            dur_q         <= seg_dur;
         end
         if (load_go) begin
            seen_seg <= 1'b1;
            if (dur_q == '0) seg_count <= seg_count + 16'd1;
            else             remaining <= dur_q;
         end
         if (state == ST_RUN && tick && remaining != '0) begin
            remaining <= remaining - 1'b1;
            if (remaining == DUR_W'(1)) seg_count <= seg_count + 16'd1;
         end
         // Coasting through FETCH once a run has started means the host fell behind.
         if (state == ST_FETCH && tick && seen_seg) underrun <= 1'b1;
         if (state == ST_ABORT && tick_d && pg_stopped) aborted <= 1'b1;
      end
   end

   // The load strobe is withdrawn combinationally if an abort lands on the load cycle.
   assign pg_load         = load_q && !abort_req;
   assign pg_acc_step     = tick;
   assign pg_set_x        = pg_load && desc.flags[SF_X];
   assign pg_set_v        = pg_load && desc.flags[SF_V];
   assign pg_set_a        = pg_load && desc.flags[SF_A];
   assign pg_set_j        = pg_load && desc.flags[SF_J];
   assign pg_set_jj       = pg_load && desc.flags[SF_JJ];
   assign pg_set_target_v = pg_load && desc.flags[SF_TARGET_V];
   assign pg_x_val        = desc.x;
   assign pg_v_val        = desc.v;
   assign pg_a_val        = desc.a;
   assign pg_j_val        = desc.j;
   assign pg_jj_val       = desc.jj;
   assign pg_target_v_val = desc.target_v;

endmodule

// File: tb/tb_acc_segment_sequencer.sv
// tb/tb_acc_segment_sequencer.sv - directed self-checking bench for acc_segment_sequencer
module tb_acc_segment_sequencer;

   localparam int STEP_DIV = 4;
   localparam int DUR_W    = 32;

   logic             clk = 1'b0;
   logic             reset, start, abort_req, seg_valid, seg_ready;
   logic [6:0]       seg_flags;
   logic [63:0]      seg_x;
   logic [31:0]      seg_v, seg_a, seg_j, seg_jj, seg_target_v;
   logic [DUR_W-1:0] seg_dur;
   logic             pg_load, pg_acc_step;
   logic             pg_set_x, pg_set_v, pg_set_a, pg_set_j, pg_set_jj, pg_set_target_v;
   logic [63:0]      pg_x_val;
   logic [31:0]      pg_v_val, pg_a_val, pg_j_val, pg_jj_val, pg_target_v_val;
   logic             pg_abort, pg_stopped, busy, underrun, aborted;
   logic [15:0]      seg_count;

   int checks = 0, errors = 0;
   int cyc = 0, last_tick = 0, last_gap = 0, load_cnt = 0, load0 = 0;

   always #5 clk = ~clk;

   acc_segment_sequencer #(.STEP_DIV(STEP_DIV), .DUR_W(DUR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .abort_req(abort_req),
      .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_flags(seg_flags),
      .seg_x(seg_x), .seg_v(seg_v), .seg_a(seg_a), .seg_j(seg_j), .seg_jj(seg_jj),
      .seg_target_v(seg_target_v), .seg_dur(seg_dur),
      .pg_load(pg_load), .pg_acc_step(pg_acc_step),
      .pg_set_x(pg_set_x), .pg_set_v(pg_set_v), .pg_set_a(pg_set_a), .pg_set_j(pg_set_j),
      .pg_set_jj(pg_set_jj), .pg_set_target_v(pg_set_target_v),
      .pg_x_val(pg_x_val), .pg_v_val(pg_v_val), .pg_a_val(pg_a_val), .pg_j_val(pg_j_val),
      .pg_jj_val(pg_jj_val), .pg_target_v_val(pg_target_v_val),
      .pg_abort(pg_abort), .pg_stopped(pg_stopped), .busy(busy),
      .underrun(underrun), .aborted(aborted), .seg_count(seg_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Loads are counted mid-cycle; ticks are timed just after the edge.
   task automatic step();
      @(negedge clk);
      if (pg_load) load_cnt++;
      @(posedge clk);
      #1;
      cyc++;
      if (pg_acc_step) begin
         last_gap  = cyc - last_tick;
         last_tick = cyc;
      end
   endtask

   task automatic wait_tick(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!pg_acc_step && n < 20);
      if (!pg_acc_step) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic stop_seq(input string tag);
      wait_tick(tag);
      pg_stopped = 1'b1;
      step();
      step();
      pg_stopped = 1'b0;
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic do_start(input logic [6:0] f, input logic [31:0] dur);
      seg_flags = f;
      seg_dur   = dur;
      start     = 1'b1;
      seg_valid = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort_req = 1'b0; seg_valid = 1'b0; pg_stopped = 1'b0;
      seg_flags = '0; seg_x = '0; seg_v = '0; seg_a = '0; seg_j = '0; seg_jj = '0;
      seg_target_v = '0; seg_dur = '0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_ready", seg_ready, 0);
      check("rst_step", pg_acc_step, 0);
      check("rst_load", pg_load, 0);
      check("rst_x_val", pg_x_val, 0);
      check("rst_count", seg_count, 0);
      reset = 1'b0;
      step();

      // single segment
      seg_v = 32'd1000;
      load0 = load_cnt;
      do_start(7'b1000010, 5);
      check("t1_ready", seg_ready, 1);
      step();
      seg_valid = 1'b0;
      check("t1_load", pg_load, 1);
      check("t1_set_v", pg_set_v, 1);
      check("t1_set_x", pg_set_x, 0);
      check("t1_v_val", pg_v_val, 1000);
      for (int i = 0; i < 5; i++) begin
         wait_tick("t1_tick");
         if (i > 0) check("t1_gap", last_gap, 4);
      end
      step();
      check("t1_count", seg_count, 1);
      check("t1_stop_ready", seg_ready, 0);
      check("t1_stop_busy", busy, 1);
      stop_seq("t1");
      check("t1_loads", load_cnt - load0, 1);
      check("t1_count_idle", seg_count, 1);

      // abort is ignored while idle
      abort_req = 1'b1;
      step();
      check("idle_abort", pg_abort, 0);
      check("idle_busy", busy, 0);
      abort_req = 1'b0;

      // back-to-back segments, descriptor always valid
      seg_v = 32'd2000;
      load0 = load_cnt;
      do_start(7'b0000010, 3);
      for (int s = 0; s < 3; s++) begin
         seg_flags = (s == 2) ? 7'b1000010 : 7'b0000010;
         step();
         check("t2_load", pg_load, 1);
         for (int k = 0; k < 3; k++) begin
            wait_tick("t2_tick");
            if (s > 0 || k > 0) check("t2_gap", last_gap, 4);
         end
         step();
      end
      seg_valid = 1'b0;
      check("t2_count", seg_count, 3);
      check("t2_underrun", underrun, 0);
      check("t2_stop_ready", seg_ready, 0);
      check("t2_loads", load_cnt - load0, 3);
      stop_seq("t2");

      // underrun: second descriptor withheld for 10 clocks
      do_start(7'b0000010, 3);
      step();
      seg_valid = 1'b0;
      for (int i = 0; i < 3; i++) wait_tick("t3_tick");
      step();
      check("t3_count1", seg_count, 1);
      check("t3_fetch", seg_ready, 1);
      repeat (10) step();
      check("t3_underrun", underrun, 1);
      seg_flags = 7'b1000001;
      seg_x     = 64'h0123_4567_89AB_CDEF;
      seg_dur   = 2;
      seg_valid = 1'b1;
      step();
      seg_valid = 1'b0;
      check("t3_load", pg_load, 1);
      check("t3_set_x", pg_set_x, 1);
      check("t3_x_val", pg_x_val, 64'h0123_4567_89AB_CDEF);
      check("t3_deferred_none", pg_acc_step, 0);
      step();
      check("t3_deferred_tick", pg_acc_step, 1);
      check("t3_gap5", last_gap, 5);
      wait_tick("t3_tick2");
      check("t3_gap3", last_gap, 3);
      step();
      check("t3_count2", seg_count, 2);
      check("t3_underrun_hold", underrun, 1);
      stop_seq("t3");

      // abort in RUN with remaining = 7
      seg_a = 32'hDEAD_0001;
      do_start(7'b0000100, 10);
      step();
      seg_valid = 1'b0;
      for (int i = 0; i < 3; i++) wait_tick("t4_tick");
      step();
      abort_req = 1'b1;
      step();
      abort_req = 1'b0;
      check("t4_pg_abort", pg_abort, 1);
      check("t4_ready", seg_ready, 0);
      check("t4_busy", busy, 1);
      wait_tick("t4_abort_tick1");
      stop_seq("t4");
      check("t4_aborted", aborted, 1);
      check("t4_count", seg_count, 0);

      // load-only segment, then abort on the load cycle
      seg_jj = 32'd7;
      load0  = load_cnt;
      do_start(7'b0010000, 0);
      step();
      check("t5_load", pg_load, 1);
      check("t5_set_jj", pg_set_jj, 1);
      check("t5_jj_val", pg_jj_val, 7);
      seg_flags = 7'b1000001;
      seg_dur   = 5;
      step();
      check("t5_count", seg_count, 1);
      check("t5_fetch", seg_ready, 1);
      step();
      abort_req = 1'b1;
      #1;
      check("t5_load_suppressed", pg_load, 0);
      step();
      abort_req = 1'b0;
      seg_valid = 1'b0;
      check("t5_pg_abort", pg_abort, 1);
      stop_seq("t5");
      check("t5_aborted", aborted, 1);
      check("t5_count_hold", seg_count, 1);
      check("t5_loads", load_cnt - load0, 1);

      // reset asserted mid-run
      seg_j = 32'hFFFF_FFFB;
      do_start(7'b0001000, 5);
      step();
      seg_valid = 1'b0;
      check("t6_j_val", pg_j_val, 32'hFFFF_FFFB);
      check("t6_set_j", pg_set_j, 1);
      wait_tick("t6_tick");
      check("t6_busy_run", busy, 1);
      reset = 1'b1;
      step();
      check("t6_busy", busy, 0);
      check("t6_ready", seg_ready, 0);
      check("t6_step", pg_acc_step, 0);
      check("t6_j_cleared", pg_j_val, 0);
      check("t6_abort", pg_abort, 0);
      reset = 1'b0;
      repeat (8) step();
      check("t6_stay_idle", busy, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("t6_restart_busy", busy, 1);
      check("t6_restart_ready", seg_ready, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
